// File: rtl/uvma_rvfi_retire_sequencer.sv
// Merges two RVFI retirement channels into a single stream released in ascending
// rvfi_order, with pulses for order gaps, dropped duplicates and head timeouts.
module uvma_rvfi_retire_sequencer #(
   parameter int unsigned         ORDER_WL    = 64,
   parameter int unsigned         DATA_W      = 256,
   parameter int unsigned         DEPTH       = 4,
   parameter logic [ORDER_WL-1:0] ORDER_START = '0,
   parameter int unsigned         TIMEOUT     = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ch0_valid,
   input  logic [ORDER_WL-1:0] ch0_order,
   input  logic [DATA_W-1:0]   ch0_data,
   output logic                ch0_ready,
   input  logic                ch1_valid,
   input  logic [ORDER_WL-1:0] ch1_order,
   input  logic [DATA_W-1:0]   ch1_data,
   output logic                ch1_ready,
   output logic                out_valid,
   output logic [ORDER_WL-1:0] out_order,
   output logic [DATA_W-1:0]   out_data,
   input  logic                out_ready,
   output logic                err_gap,
   output logic                err_dup,
   output logic                err_timeout,
   output logic [ORDER_WL-1:0] expected_order
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [1:0]          in_valid;
   logic [ORDER_WL-1:0] in_order [2];
   logic [DATA_W-1:0]   in_data [2];
   logic [1:0]          in_ready;
   logic [1:0]          head_valid;
   logic [ORDER_WL-1:0] head_order [2];
   logic [DATA_W-1:0]   head_data [2];
   logic [1:0]          pop;

   assign in_valid    = {ch1_valid, ch0_valid};
   assign in_order[0] = ch0_order;
   assign in_order[1] = ch1_order;
   assign in_data[0]  = ch0_data;
   assign in_data[1]  = ch1_data;
   assign ch0_ready   = in_ready[0];
   assign ch1_ready   = in_ready[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [ORDER_WL-1:0] order_mem [DEPTH];
         logic [DATA_W-1:0]   data_mem [DEPTH];
         logic [PTR_W:0]      wr_ptr_reg;
         logic [PTR_W:0]      rd_ptr_reg;
         logic                full;
         logic                push;

         // The extra MSB separates full (MSBs differ) from empty (pointers equal).
         assign full = (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]) &&
                       (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);
         assign push           = in_valid[gi] && !full;
         assign in_ready[gi]   = !full;
         assign head_valid[gi] = (wr_ptr_reg != rd_ptr_reg);
         assign head_order[gi] = order_mem[rd_ptr_reg[PTR_W-1:0]];
         assign head_data[gi]  = data_mem[rd_ptr_reg[PTR_W-1:0]];

         always_ff @(posedge clk) begin
            if (push) begin
               order_mem[wr_ptr_reg[PTR_W-1:0]] <= in_order[gi];
               data_mem[wr_ptr_reg[PTR_W-1:0]]  <= in_data[gi];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
            end else begin
               if (push)
                  wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (pop[gi])
                  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
         end
      end
   endgenerate

   logic                out_valid_reg;
   logic [ORDER_WL-1:0] out_order_reg;
   logic [DATA_W-1:0]   out_data_reg;
   logic                err_gap_reg, err_dup_reg, err_timeout_reg;
   logic [ORDER_WL-1:0] exp_reg, exp_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;

   logic                can_load, match0, match1;
   logic                rel_valid, rel_sel;
   logic                sel_gap, sel_dup, sel_tmo;
   logic [ORDER_WL-1:0] rel_order;

   always_comb begin
      rel_valid = 1'b0;
      rel_sel   = 1'b0;
      pop       = 2'b00;
      sel_gap   = 1'b0;
      sel_dup   = 1'b0;
      sel_tmo   = 1'b0;
      cnt_next  = cnt_reg;
      exp_next  = exp_reg;
      can_load  = !out_valid_reg || out_ready;
      match0    = head_valid[0] && (head_order[0] == exp_reg);
      match1    = head_valid[1] && (head_order[1] == exp_reg);
      if (can_load) begin
         if (head_valid == 2'b11 && head_order[0] == head_order[1]) begin
            rel_valid = 1'b1;
            pop       = 2'b11;
            sel_dup   = 1'b1;
         end else if (match0) begin
            rel_valid = 1'b1;
            pop       = 2'b01;
         end else if (match1) begin
            rel_valid = 1'b1;
            rel_sel   = 1'b1;
            pop       = 2'b10;
         end else if (head_valid == 2'b11) begin
            rel_valid = 1'b1;
            rel_sel   = head_order[1] < head_order[0];
            pop       = rel_sel ? 2'b10 : 2'b01;
            sel_gap   = 1'b1;
         end else if (head_valid != 2'b00) begin
            // A lone out-of-order head waits for its peer until the counter expires.
            if (cnt_reg == CNT_W'(TIMEOUT)) begin
               rel_valid = 1'b1;
               rel_sel   = head_valid[1];
               pop       = head_valid;
               sel_gap   = 1'b1;
               sel_tmo   = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
      end
      rel_order = rel_sel ? head_order[1] : head_order[0];
      if (rel_valid) begin
         exp_next = rel_order + ORDER_WL'(1);
         cnt_next = '0;
      end
      if (head_valid == 2'b00)
         cnt_next = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg   <= 1'b0;
         out_order_reg   <= '0;
         out_data_reg    <= '0;
         err_gap_reg     <= 1'b0;
         err_dup_reg     <= 1'b0;
         err_timeout_reg <= 1'b0;
         exp_reg         <= ORDER_START;
         cnt_reg         <= '0;
      end else begin
         err_gap_reg     <= sel_gap;
         err_dup_reg     <= sel_dup;
         err_timeout_reg <= sel_tmo;
         exp_reg         <= exp_next;
         cnt_reg         <= cnt_next;
         if (can_load)
            out_valid_reg <= rel_valid;
         if (rel_valid) begin
            out_order_reg <= rel_order;
            out_data_reg  <= rel_sel ? head_data[1] : head_data[0];
         end
      end
   end

   assign out_valid      = out_valid_reg;
   assign out_order      = out_order_reg;
   assign out_data       = out_data_reg;
   assign err_gap        = err_gap_reg;
   assign err_dup        = err_dup_reg;
   assign err_timeout    = err_timeout_reg;
   assign expected_order = exp_reg;
endmodule

// File: tb/tb_uvma_rvfi_retire_sequencer.sv
// Directed bench for uvma_rvfi_retire_sequencer: ordering, gaps, timeout,
// duplicates under backpressure and mid-stream reset.
module tb_uvma_rvfi_retire_sequencer;
   localparam int OW      = 64;
   localparam int DW      = 256;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          ch0_valid, ch1_valid, ch0_ready, ch1_ready;
   logic [OW-1:0] ch0_order, ch1_order, out_order, expected_order;
   logic [DW-1:0] ch0_data, ch1_data, out_data;
   logic          out_valid, out_ready;
   logic          err_gap, err_dup, err_timeout;
   logic [2:0]    errs;
   int            total = 0;
   int            bad = 0;
   int            n;

   assign errs = {err_gap, err_dup, err_timeout};

   always #5 clk = ~clk;

   uvma_rvfi_retire_sequencer #(
      .ORDER_WL(OW), .DATA_W(DW), .DEPTH(DEPTH), .ORDER_START('0), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .ch0_valid(ch0_valid), .ch0_order(ch0_order), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
      .ch1_valid(ch1_valid), .ch1_order(ch1_order), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
      .out_valid(out_valid), .out_order(out_order), .out_data(out_data), .out_ready(out_ready),
      .err_gap(err_gap), .err_dup(err_dup), .err_timeout(err_timeout),
      .expected_order(expected_order)
   );

   function automatic logic [DW-1:0] pay(input logic [OW-1:0] o);
      return {o, ~o, o ^ 64'h5a5a_5a5a_5a5a_5a5a, 64'h0123_4567_89ab_cdef};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v0, input logic [OW-1:0] o0, input logic v1, input logic [OW-1:0] o1);
      ch0_valid = v0;
      ch0_order = o0;
      ch0_data  = pay(o0);
      ch1_valid = v1;
      ch1_order = o1;
      ch1_data  = pay(o1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drv(1'b0, '0, 1'b0, '0);
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_out(input int limit, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!out_valid && cnt < limit);
   endtask

   always @(posedge clk)
      if (!reset && out_valid && out_ready)
         $display("txn order=%0d gap=%0b dup=%0b tmo=%0b", out_order, err_gap, err_dup, err_timeout);

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench stuck");
   end

   initial begin
      reset     = 1'b1;
      out_ready = 1'b1;
      drv(1'b0, '0, 1'b0, '0);
      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_ready", {ch0_ready, ch1_ready}, 2'b11);
      check("rst_exp", expected_order, 0);
      check("rst_err", errs, 0);
      check("rst_order", out_order, 0);
      reset = 1'b0;

      // Interleaved in-order streams: 0..5 released back-to-back.
      for (int c = 0; c < 8; c++) begin
         logic [63:0] e;
         if (c < 3) drv(1'b1, 64'(2 * c), 1'b1, 64'(2 * c + 1));
         else       drv(1'b0, '0, 1'b0, '0);
         tick();
         e = 64'(c - 1);
         if (c >= 1 && c <= 6) begin
            check("alt_valid", out_valid, 1);
            check("alt_order", out_order, e);
            check("alt_data", out_data[191:128], ~e);
            check("alt_err", errs, 0);
         end
      end
      check("alt_idle", out_valid, 0);
      check("alt_exp", expected_order, 6);

      // Reversed arrival: order 1 must wait for order 0.
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drv(c == 3, 64'd0, c == 0, 64'd1);
         tick();
         if (c <= 3) begin
            check("rev_hold", out_valid, 0);
         end else if (c == 4) begin
            check("rev_v0", out_valid, 1);
            check("rev_o0", out_order, 0);
            check("rev_e0", errs, 0);
         end else if (c == 5) begin
            check("rev_v1", out_valid, 1);
            check("rev_o1", out_order, 1);
            check("rev_e1", errs, 0);
         end else begin
            check("rev_idle", out_valid, 0);
            check("rev_exp", expected_order, 2);
         end
      end

      // Gap: 3 and 5 arrive after 0; 3 released with gap, 5 later via timeout.
      do_reset();
      drv(1'b1, 64'd0, 1'b0, '0);
      tick();
      drv(1'b1, 64'd3, 1'b1, 64'd5);
      tick();
      check("gap_o0", out_order, 0);
      check("gap_e0", errs, 0);
      drv(1'b0, '0, 1'b0, '0);
      tick();
      check("gap_v3", out_valid, 1);
      check("gap_o3", out_order, 3);
      check("gap_e3", errs, 3'b100);
      check("gap_exp3", expected_order, 4);
      wait_out(40, n);
      check("gap_seen5", out_valid, 1);
      check("gap_o5", out_order, 5);
      check("gap_e5", errs, 3'b101);
      check("gap_exp5", expected_order, 6);

      // Timeout: lone order 7; counter counts 0..TIMEOUT then releases next edge.
      do_reset();
      drv(1'b1, 64'd7, 1'b0, '0);
      tick();
      drv(1'b0, '0, 1'b0, '0);
      wait_out(40, n);
      check("tmo_wait", 64'(n), 64'(TIMEOUT + 1));
      check("tmo_order", out_order, 7);
      check("tmo_err", errs, 3'b101);
      check("tmo_exp", expected_order, 8);
      tick();
      check("tmo_pulse", errs, 0);
      check("tmo_idle", out_valid, 0);

      // Duplicate order 2 on both channels, then backpressure fills ch0.
      do_reset();
      drv(1'b1, 64'd0, 1'b0, '0);
      tick();
      drv(1'b1, 64'd1, 1'b0, '0);
      tick();
      drv(1'b1, 64'd2, 1'b1, 64'd2);
      tick();
      check("dup_o1", out_order, 1);
      drv(1'b1, 64'd3, 1'b0, '0);
      tick();
      check("dup_v2", out_valid, 1);
      check("dup_o2", out_order, 2);
      check("dup_err", errs, 3'b010);
      check("dup_exp", expected_order, 3);
      out_ready = 1'b0;
      for (int c = 4; c <= 8; c++) begin
         if (c <= 6) drv(1'b1, 64'(c), 1'b0, '0);
         else        drv(1'b1, 64'd7, 1'b0, '0);
         tick();
         check("bp_valid", out_valid, 1);
         check("bp_order", out_order, 2);
         check("bp_err", errs, 0);
         check("bp_ch1", ch1_ready, 1);
         if (c >= 6) check("bp_full", ch0_ready, 0);
      end
      drv(1'b0, '0, 1'b0, '0);
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (c < 4) begin
            check("drain_v", out_valid, 1);
            check("drain_o", out_order, 64'(3 + c));
         end else begin
            check("drain_idle", out_valid, 0);
            check("drain_exp", expected_order, 7);
         end
      end

      // Mid-stream reset discards buffered entries.
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drv(1'b1, 64'(c), 1'b0, '0);
         tick();
      end
      drv(1'b0, '0, 1'b0, '0);
      check("mr_pre", out_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_valid", out_valid, 0);
      check("mr_ready", {ch0_ready, ch1_ready}, 2'b11);
      check("mr_exp", expected_order, 0);
      check("mr_err", errs, 0);
      out_ready = 1'b1;
      drv(1'b0, '0, 1'b1, 64'd0);
      tick();
      drv(1'b0, '0, 1'b0, '0);
      check("mr_lat", out_valid, 0);
      tick();
      check("mr_v0", out_valid, 1);
      check("mr_o0", out_order, 0);
      check("mr_e0", errs, 0);
      tick();
      check("mr_end", out_valid, 0);
      check("mr_exp1", expected_order, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uvma_rvfi_retire_sequencer.md
Name: uvma_rvfi_retire_sequencer

Overview:
- Merges two RVFI retirement channels (e.g. dual-issue or split pipe/debug retire ports) into one in-order stream keyed on rvfi_order.
- Feeds the single RVFI instruction interface consumed by the RVFI instruction monitor.
- Buffers each channel in a small FIFO and releases entries strictly in ascending order.
- Flags order gaps, duplicates and stalls.

Parameters:
- ORDER_WL, 64: width of the rvfi_order field.
- DATA_W, 256: width of the opaque packed retirement payload (insn, pc, gpr, mem fields).
- DEPTH, 4: per-channel FIFO depth; power of 2, minimum 2.
- ORDER_START, 0: first expected order value after reset.
- TIMEOUT, 16: cycles a non-matching head may wait before a forced release.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ch0_valid  in  1  channel 0 retirement valid
- ch0_order  in  ORDER_WL  channel 0 rvfi_order
- ch0_data  in  DATA_W  channel 0 payload
- ch0_ready  out  1  channel 0 can accept (FIFO not full)
- ch1_valid, ch1_order, ch1_data, ch1_ready  same as channel 0, for channel 1
- out_valid  out  1  merged retirement valid
- out_order  out  ORDER_WL  merged order
- out_data  out  DATA_W  merged payload
- out_ready  in  1  consumer accepts
- err_gap  out  1  one-cycle pulse: released order != expected
- err_dup  out  1  one-cycle pulse: duplicate order dropped
- err_timeout  out  1  one-cycle pulse: forced release after TIMEOUT
- expected_order  out  ORDER_WL  next order awaited

Behaviour:
- Reset: all outputs 0 except ch0_ready=ch1_ready=1 and expected_order=ORDER_START. FIFOs emptied, timeout counter cleared. Reset takes effect mid-operation the same way: in-flight data is discarded and out_valid drops the cycle after reset is sampled.
- Input push: an entry is pushed when chN_valid && chN_ready. chN_ready = !full_N, registered from FIFO state. Simultaneous push and pop on a full FIFO is not accepted.
- Output register: a single stage. The selector loads it when it is empty, or when out_valid && out_ready in the same cycle, giving full throughput.
  - Latency: an input pushed at cycle t, with a matching order and an empty output register, gives out_valid at t+2 (FIFO write at t+1, output register at t+2).
  - out_order and out_data are held stable while out_valid && !out_ready.
- Selection, evaluated on FIFO heads H0/H1 when the output register can load (priority order):
  1. Both heads valid and order0==order1: release H0 and pop both. Pulse err_dup. expected = order0+1.
  2. A head equals expected: release it and pop. If both match, rule 1 applies.
  3. Both heads valid, neither matches: release the smaller order and pop it. Pulse err_gap. expected = released+1.
  4. Exactly one head valid, not matching: hold and increment the timeout counter. When the counter reaches TIMEOUT, release that head, pulse err_gap and err_timeout, set expected = released+1, and clear the counter.
  5. Otherwise idle.
- Timeout counter: cleared on any release or when both FIFOs are empty. It saturates at TIMEOUT.
- Order arithmetic: order comparisons are unsigned. expected+1 wraps modulo 2^ORDER_WL. Order wrap is not treated as a gap: a release of 0 when expected is 0 after a wrap is a match.
- Error pulses: pulses are asserted in the cycle the output register loads and are exclusive to that load.
- FIFO pointers: pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

Test Plan:
- In-order alternation: ch0 orders 0,2,4 and ch1 orders 1,3,5, one per cycle, out_ready=1 -> out_order 0,1,2,3,4,5 back-to-back, no error pulses, expected_order=6.
- Reversed arrival: ch1 order 1 at cycle 0, ch0 order 0 at cycle 3 -> nothing released before order 0; out_order 0 then 1; no errors.
- Gap: ch0 order 0, then ch0 order 3 and ch1 order 5 with order 1 never sent -> err_gap on the release of 3; expected_order=4; then 5 released with err_gap.
- Timeout: with expected=0, only ch0 pushes order 7 -> held for 16 cycles, then released with err_gap=err_timeout=1; expected_order=8.
- Duplicate plus backpressure: both channels push order 2 with expected=2 and out_ready=0 for 5 cycles -> out_valid stays 1 with out_order=2 held; err_dup pulses once; ch1's entry is dropped; after the FIFOs fill, ch0_ready=0 with DEPTH=4 entries.
- Mid-stream reset: reset for 1 cycle with 3 entries buffered -> the next cycle out_valid=0, ready=1, expected_order=0; post-reset order 0 is accepted normally.
